// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Packet-atomic 128-bit TLP transmit arbiter: fixed lowest-index priority with starvation promotion.
// Define TLPS_ARB_STATS_EN to add per-source packet counters and a promotion counter.
module pcileech_tlps128_tx_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk_pcie,
    input  logic                  rst,
    input  logic [NUM_IN*128-1:0] in_tdata,
    input  logic [NUM_IN*4-1:0]   in_tkeepdw,
    input  logic [NUM_IN*9-1:0]   in_tuser,
    input  logic [NUM_IN-1:0]     in_tlast,
    input  logic [NUM_IN-1:0]     in_tvalid,
    input  logic [NUM_IN-1:0]     in_has_data,
    output logic [NUM_IN-1:0]     in_tready,
    output logic [127:0]          out_tdata,
    output logic [3:0]            out_tkeepdw,
    output logic [8:0]            out_tuser,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    output logic                  out_has_data,
    input  logic                  out_tready,
`ifdef TLPS_ARB_STATS_EN
    output logic [NUM_IN*16-1:0]  stat_pkts,
    output logic [15:0]           stat_promotions,
`endif
    output logic [2:0]            grant_idx,
    output logic                  grant_active,
    output logic [NUM_IN-1:0]     urgent
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [NUM_IN-1:0] urgent_q;
    logic [NUM_IN-1:0] owns_next;
    logic [7:0]        wait_q [NUM_IN];
    logic              sel_valid, sel_urgent, take_sel, release_pkt;
    logic [2:0]        sel_idx;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        out_tdata   = '0;
        out_tkeepdw = '0;
        out_tuser   = '0;
        out_tlast   = 1'b0;
        out_tvalid  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (state_q == OWN && grant_q == 3'(i)) begin
                out_tdata   = in_tdata[i*128 +: 128];
                out_tkeepdw = in_tkeepdw[i*4 +: 4];
                out_tuser   = in_tuser[i*9 +: 9];
                out_tlast   = in_tlast[i];
                out_tvalid  = in_tvalid[i];
            end
        end
    end

    assign release_pkt  = out_tvalid && out_tready && out_tlast;
    assign out_has_data = |in_has_data;

    // Descending scans: the last hit, i.e. the lowest index, wins; urgent sources override.
    always_comb begin
        sel_valid  = 1'b0;
        sel_urgent = 1'b0;
        sel_idx    = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_has_data[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
            end
        end
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (urgent_q[i] && in_has_data[i]) begin
                sel_valid  = 1'b1;
                sel_urgent = 1'b1;
                sel_idx    = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        take_sel = (state_q == IDLE) || release_pkt;
        if (take_sel) begin
            state_d = sel_valid ? OWN : IDLE;
            grant_d = sel_valid ? sel_idx : grant_q;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            owns_next[i] = (state_d == OWN) && (grant_d == 3'(i));
            in_tready[i] = !rst && out_tready && owns_next[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            urgent_q <= '0;
            for (int i = 0; i < NUM_IN; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!in_has_data[i] || owns_next[i]) begin
                    wait_q[i]   <= '0;
                    urgent_q[i] <= 1'b0;
                end else if (wait_q[i] < LIMIT) begin
                    wait_q[i]   <= wait_q[i] + 8'd1;
                    urgent_q[i] <= (wait_q[i] == LIMIT - 8'd1);
                end else begin
                    urgent_q[i] <= 1'b1;
                end
            end
        end
    end

    assign grant_idx    = grant_q;
    assign grant_active = (state_q == OWN);
    assign urgent       = urgent_q;

`ifdef TLPS_ARB_STATS_EN
    logic [15:0] pkt_cnt [NUM_IN];

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            stat_promotions <= '0;
            for (int i = 0; i < NUM_IN; i++) pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (release_pkt && grant_q == 3'(i)) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
            end
            if (take_sel && sel_urgent && stat_promotions != 16'hFFFF)
                stat_promotions <= stat_promotions + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) stat_pkts[i*16 +: 16] = pkt_cnt[i];
    end
`endif

endmodule

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
// Directed bench for pcileech_tlps128_tx_arbiter: behavioural sources plus an in-order beat scoreboard.
`timescale 1ns/1ps
module tb_pcileech_tlps128_tx_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic         gap;
        logic [2:0]   src;
        logic [127:0] data;
        logic [3:0]   keep;
        logic [8:0]   user;
        logic         last;
    } beat_t;

    logic           clk_pcie = 1'b0;
    logic           rst;
    logic [N*128-1:0] in_tdata;
    logic [N*4-1:0] in_tkeepdw;
    logic [N*9-1:0] in_tuser;
    logic [N-1:0]   in_tlast, in_tvalid, in_has_data, in_tready;
    logic [127:0]   out_tdata;
    logic [3:0]     out_tkeepdw;
    logic [8:0]     out_tuser;
    logic           out_tlast, out_tvalid, out_has_data, out_tready;
    logic [2:0]     grant_idx;
    logic           grant_active;
    logic [N-1:0]   urgent;
`ifdef TLPS_ARB_STATS_EN
    logic [N*16-1:0] stat_pkts;
    logic [15:0]     stat_promotions;
`endif

    pcileech_tlps128_tx_arbiter #(.NUM_IN(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser),
        .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_has_data(in_has_data),
        .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeepdw(out_tkeepdw), .out_tuser(out_tuser),
        .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_has_data(out_has_data),
        .out_tready(out_tready),
`ifdef TLPS_ARB_STATS_EN
        .stat_pkts(stat_pkts), .stat_promotions(stat_promotions),
`endif
        .grant_idx(grant_idx), .grant_active(grant_active), .urgent(urgent)
    );

    always #5 clk_pcie = ~clk_pcie;

    int    checks = 0;
    int    errors = 0;
    int    pending [N];
    beat_t src_q [N][$];
    beat_t src_cur [N];
    logic [N-1:0] src_v;
    beat_t exp_q [$];

    // Values sampled at the falling edge of the most recent tick.
    logic [N-1:0] s_in_tready, s_urgent;
    logic         s_acc, s_tlast, s_grant_active, s_out_tvalid, s_rst, s_has_data;
    logic [2:0]   s_grant_idx;
    logic [127:0] s_out_tdata;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input int src, input int pkt, input int beat);
        logic [7:0] h;
        h = 8'(src * 37 + pkt * 11 + beat * 5 + 1);
        return {8'(src), 8'(pkt), 8'(beat), {13{h}}};
    endfunction

    function automatic beat_t mk_beat(input int src, input int pkt, input int b, input int nbeats);
        beat_t e;
        e.gap  = 1'b0;
        e.src  = 3'(src);
        e.data = mk_data(src, pkt, b);
        e.keep = (b == nbeats - 1) ? 4'b0011 : 4'b1111;
        e.user = {8'h00, b == 0};
        e.last = (b == nbeats - 1);
        return e;
    endfunction

    task automatic add_pkt(input int src, input int pkt, input int nbeats, input int gap_after);
        beat_t g;
        g = '{gap: 1'b1, src: 3'(src), data: '0, keep: '0, user: '0, last: 1'b0};
        for (int b = 0; b < nbeats; b++) begin
            src_q[src].push_back(mk_beat(src, pkt, b, nbeats));
            if (b == gap_after) begin
                src_q[src].push_back(g);
                src_q[src].push_back(g);
            end
        end
        pending[src]++;
        in_has_data[src] = 1'b1;
    endtask

    task automatic exp_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) exp_q.push_back(mk_beat(src, pkt, b, nbeats));
    endtask

    task automatic drive_src(input int i);
        in_tvalid[i]          = src_v[i];
        in_tdata[i*128 +: 128] = src_cur[i].data;
        in_tkeepdw[i*4 +: 4]   = src_cur[i].keep;
        in_tuser[i*9 +: 9]     = src_cur[i].user;
        in_tlast[i]            = src_cur[i].last;
        in_has_data[i]         = (pending[i] > 0);
    endtask

    // One clock: sample and score at the falling edge, then advance the source models.
    task automatic tick();
        beat_t e;
        logic [N-1:0] used;
        @(negedge clk_pcie);
        s_in_tready    = in_tready;
        s_acc          = out_tvalid && out_tready;
        s_tlast        = out_tlast;
        s_grant_active = grant_active;
        s_grant_idx    = grant_idx;
        s_out_tvalid   = out_tvalid;
        s_out_tdata    = out_tdata;
        s_urgent       = urgent;
        s_rst          = rst;
        s_has_data     = out_has_data;
        if (s_acc && !s_rst) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 160'(exp_q.size()), 160'(1));
            end else begin
                e = exp_q.pop_front();
                check("sb_beat", 160'({grant_idx, out_tlast, out_tkeepdw, out_tuser, out_tdata}),
                      160'({e.src, e.last, e.keep, e.user, e.data}));
            end
        end
        used = '0;
        for (int i = 0; i < N; i++) used[i] = s_acc && s_grant_active && (s_grant_idx == 3'(i));
        @(posedge clk_pcie);
        #1;
        if (s_rst) exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (s_rst) begin
                src_q[i].delete();
                pending[i] = 0;
                src_v[i]   = 1'b0;
            end else if (s_in_tready[i]) begin
                if (src_q[i].size() > 0) begin
                    e = src_q[i].pop_front();
                    if (e.gap) begin
                        src_v[i] = 1'b0;
                    end else begin
                        src_v[i]   = 1'b1;
                        src_cur[i] = e;
                        if (e.user[0]) pending[i]--;
                    end
                end else begin
                    src_v[i] = 1'b0;
                end
            end else if (used[i]) begin
                src_v[i] = 1'b0;
            end
            drive_src(i);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 64) begin
            tick();
            n++;
        end
        check(tag, 160'(exp_q.size()), 160'(0));
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  gaps;
        logic done;

        rst = 1'b1;
        out_tready = 1'b0;
        in_tdata = '0; in_tkeepdw = '0; in_tuser = '0;
        in_tlast = '0; in_tvalid = '0; in_has_data = '0;
        src_v = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = 0;
            src_cur[i] = '{gap: 1'b0, src: '0, data: '0, keep: '0, user: '0, last: 1'b0};
        end
        @(posedge clk_pcie);
        #1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_grant_active", 160'(s_grant_active), 160'(0));
        check("rst_grant_idx", 160'(s_grant_idx), 160'(0));
        check("rst_urgent", 160'(s_urgent), 160'(0));
        check("rst_out", 160'({s_out_tvalid, s_out_tdata}), 160'(0));
        check("rst_in_tready", 160'(s_in_tready), 160'(0));

        // Single source, 3-beat packet.
        out_tready = 1'b1;
        add_pkt(2, 0, 3, -1);
        exp_pkt(2, 0, 3);
        tick();
        check("t1_tready_grant", 160'(s_in_tready), 160'(4'b0100));
        check("t1_idle_before", 160'(s_grant_active), 160'(0));
        check("t1_has_data", 160'(s_has_data), 160'(1));
        for (int b = 1; b <= 3; b++) begin
            tick();
            check("t1_owner", 160'({s_grant_active, s_grant_idx}), 160'({1'b1, 3'd2}));
            check("t1_tready", 160'(s_in_tready), 160'(b < 3 ? 4'b0100 : 4'b0000));
        end
        tick();
        check("t1_released", 160'({s_grant_active, s_out_tvalid}), 160'(0));
        drain("t1_drain");

        // Priority and back-to-back: sources 0, 1, 3 all ready.
        add_pkt(0, 1, 2, -1);
        add_pkt(1, 1, 2, -1);
        add_pkt(3, 1, 2, -1);
        exp_pkt(0, 1, 2);
        exp_pkt(1, 1, 2);
        exp_pkt(3, 1, 2);
        for (k = 0; k < 8; k++) begin
            tick();
            if (k == 0) check("t2_first_grant", 160'(s_in_tready), 160'(4'b0001));
            if (k >= 1 && k <= 6) check("t2_no_bubble", 160'(s_acc), 160'(1));
            if (k == 2) check("t2_regrant_1", 160'(s_in_tready), 160'(4'b0010));
            if (k == 4) check("t2_regrant_3", 160'(s_in_tready), 160'(4'b1000));
            if (k == 7) check("t2_idle", 160'(s_grant_active), 160'(0));
        end
        drain("t2_drain");

        // Backpressure toggling and a two-cycle source gap on source 1; source 2 waits.
        add_pkt(1, 2, 4, 1);
        add_pkt(2, 2, 1, -1);
        exp_pkt(1, 2, 4);
        exp_pkt(2, 2, 1);
        done = 1'b0;
        gaps = 0;
        for (k = 0; k < 40 && !done; k++) begin
            out_tready = (k % 2 == 0);
            tick();
            if (s_grant_active) begin
                check("t3_hold_owner", 160'(s_grant_idx), 160'(1));
                if (!s_out_tvalid) gaps++;
            end
            if (s_acc && s_tlast) done = 1'b1;
            else check("t3_no_other_tready", 160'(s_in_tready & 4'b1101), 160'(0));
        end
        check("t3_timeout", 160'(done), 160'(1));
        check("t3_gap_seen", 160'(gaps >= 2), 160'(1));
        out_tready = 1'b1;
        drain("t3_drain");

        // Starvation: source 0 streams 1-beat packets while source 3 waits.
        for (int p = 0; p < 12; p++) add_pkt(0, 10 + p, 1, -1);
        add_pkt(3, 3, 1, -1);
        for (int p = 0; p < 8; p++) exp_pkt(0, 10 + p, 1);
        exp_pkt(3, 3, 1);
        for (int p = 8; p < 12; p++) exp_pkt(0, 10 + p, 1);
        for (k = 0; k < 10; k++) begin
            tick();
            if (k < 8) check("t4_not_urgent", 160'(s_urgent[3]), 160'(0));
            if (k >= 1 && k < 8) check("t4_src0_owns", 160'(s_grant_idx), 160'(0));
            if (k == 8) begin
                check("t4_urgent", 160'(s_urgent[3]), 160'(1));
                check("t4_promote_tready", 160'(s_in_tready), 160'(4'b1000));
            end
            if (k == 9) begin
                check("t4_src3_owns", 160'(s_grant_idx), 160'(3));
                check("t4_urgent_cleared", 160'(s_urgent[3]), 160'(0));
            end
        end
        drain("t4_drain");

        // Reset on the second beat of a 4-beat packet from source 1.
        add_pkt(1, 5, 4, -1);
        add_pkt(2, 5, 2, -1);
        exp_pkt(1, 5, 4);
        done = 1'b0;
        for (k = 0; k < 10 && !done; k++) begin
            tick();
            if (s_acc) done = 1'b1;
        end
        check("t5_first_beat", 160'(done), 160'(1));
        rst = 1'b1;
        tick();
        check("t5_rst_tready", 160'(s_in_tready), 160'(0));
        rst = 1'b0;
        tick();
        check("t5_grant_dropped", 160'({s_grant_active, s_grant_idx}), 160'(0));
        check("t5_out_zero", 160'({s_out_tvalid, s_out_tdata}), 160'(0));
        check("t5_urgent_zero", 160'(s_urgent), 160'(0));
`ifdef TLPS_ARB_STATS_EN
        check("t5_stat_pkts", 160'(stat_pkts), 160'(0));
`endif

        // Normal operation after reset.
        add_pkt(3, 6, 2, -1);
        exp_pkt(3, 6, 2);
        drain("t5_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcileech_tlps128_tx_arbiter.md
Name: pcileech_tlps128_tx_arbiter

Overview:
- Packet-atomic arbiter and mux that shares the single 128-bit TLP transmit path into the PCIe core among NUM_IN TLP-AXI-stream sources (cfg responses, BAR responses, host FIFO, static TLPs).
- Priority is fixed, lowest index first.
- Per-input aging counters promote starved sources, so a busy high-priority source cannot lock out lower ones indefinitely.
- Sits between the TLP sources and the core TX interface in the clk_pcie domain.

Parameters:
- NUM_IN, 4: number of source streams (2..8).
- STARVE_LIMIT, 64: cycles a source may wait with has_data before it becomes urgent (1..255).

Ports:
- clk_pcie  in  1  PCIe user clock.
- rst  in  1  reset, synchronous, active-high.
- in_tdata  in  NUM_IN*128  per-source data; source i occupies [i*128 +: 128].
- in_tkeepdw  in  NUM_IN*4  per-source DW keep.
- in_tuser  in  NUM_IN*9  per-source tuser; bit 0 = first beat.
- in_tlast  in  NUM_IN  per-source last beat.
- in_tvalid  in  NUM_IN  per-source valid.
- in_has_data  in  NUM_IN  source holds at least one complete packet.
- in_tready  out  NUM_IN  per-source read enable.
- out_tdata  out  128  muxed data.
- out_tkeepdw  out  4  muxed keep.
- out_tuser  out  9  muxed tuser.
- out_tlast  out  1  muxed last.
- out_tvalid  out  1  muxed valid.
- out_has_data  out  1  OR of in_has_data.
- out_tready  in  1  core ready.
- grant_idx  out  3  registered index of the owning source.
- grant_active  out  1  registered: a source currently owns the path.
- urgent  out  NUM_IN  registered starvation flags.

Behaviour:
- Reset values: grant_active=0, grant_idx=0, urgent=0, all wait counters=0. While grant_active=0, out_tvalid/tlast/tdata/tkeepdw/tuser are all 0.
- Source contract: each source presents data 1 clk after its in_tready. The mux path is combinational from the registered grant_idx, so the block adds 0 cycles of latency.
- States:
  - IDLE (grant_active=0).
  - OWN (grant_active=1, owner=grant_idx).
- Selection (sel_next):
  - If any urgent[i]&&in_has_data[i]: lowest such i.
  - Else: lowest i with in_has_data[i].
  - Else: none.
- Release: the owner releases the path on the cycle out_tvalid&&out_tready&&out_tlast.
- Next owner (owner_next):
  - IDLE, or OWN with release this cycle: sel_next, or IDLE if none.
  - OWN without release: unchanged.
- in_tready[i] = out_tready && owner_next valid && owner_next==i. Release and re-grant in the same cycle gives back-to-back packets with no bubble.
- Grant is held mid-packet even if out_tvalid drops (source gap) or out_tready is low. No preemption inside a packet.
- Wait counter[i] (8-bit, saturating at STARVE_LIMIT):
  - Increments when in_has_data[i] && owner_next!=i.
  - Clears when owner_next==i or in_has_data[i]=0.
  - urgent[i] <= (counter reaches STARVE_LIMIT).
  - urgent[i] clears when i is granted.
- Simultaneous urgency: among urgent sources, the lowest index wins. The others keep counting, saturated and still urgent, and win on later releases.
- Source drops in_has_data while owning mid-packet: the grant is still held until tlast.
- Reset mid-packet: the grant is dropped, output goes to zeros, and in_tready=0 in the reset cycle. The sources are reset by the same rst.
- grant_idx beyond NUM_IN-1 is never produced.

Optional Feature:
- Macro TLPS_ARB_STATS_EN.
- When defined:
  - Adds output stat_pkts (NUM_IN*16): per-source count of released packets, wrapping at 16 bits.
  - Adds output stat_promotions (16): count of grants won via urgency, saturating at 0xFFFF.
  - Both cleared by rst.
- When undefined: the ports and logic are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Single source: NUM_IN=4. Source 2 sends a 3-beat packet with out_tready=1 → grant_idx=2 for 3 beats, no other in_tready asserted, grant_active=0 after the tlast beat.
- Priority and back-to-back: sources 1 and 3 both have_data while source 0 sends a 2-beat packet → source 1 granted in the same cycle as source 0's tlast, then source 3; zero idle cycles between packets.
- Backpressure and gap: out_tready toggles 1/0 and source 1's tvalid drops for 2 cycles mid-packet → grant stays on 1, data beats are delivered in order, no other in_tready asserted.
- Starvation: STARVE_LIMIT=8, source 0 sends continuous 1-beat packets, source 3 has_data → urgent[3]=1 after 8 waiting cycles, source 3 granted on the next release ahead of source 0, urgent[3] then cleared.
- Reset mid-packet: rst asserted on beat 2 of a 4-beat packet from source 1 → next cycle grant_active=0, out_tvalid=0, counters=0, and with TLPS_ARB_STATS_EN defined stat_pkts=0.
